alu_driver: RTL and testbench

//  Initiator side of the registered 8-bit ALU port (A, B, CTR in; O out).

---
 rtl/alu_driver.sv | 91 +++++++++
 tb/tb_alu_driver.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_driver.sv
// Initiator for a registered ALU port: takes one command over valid/ready,
// waits out the ALU pipeline, and returns the captured result with flags.
module alu_driver #(
  parameter int W       = 8,
  parameter int ALU_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [3:0]       alu_ctr,
  input  logic [W-1:0]     alu_o,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic [3:0]       res_op,
  output logic             res_zero,
  output logic             res_illegal,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  localparam int LAT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [LAT_W-1:0] cnt;
  logic             op_undef;

  // Opcodes 0010..0111 have no defined ALU function.
  assign op_undef  = (res_op[3] == 1'b0) && (res_op[2:1] != 2'b00);
  assign cmd_ready = rst_n && (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctr     <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_op      <= '0;
      res_zero    <= 1'b0;
      res_illegal <= 1'b0;
      op_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_ctr <= cmd_op;
            res_op  <= cmd_op;
            cnt     <= LAT_W'(ALU_LAT);
            state   <= WAIT;
          end
        end
        WAIT: begin
          // The ALU has no reset, so the full latency is waited every time.
          if (cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
          end else begin
            res_data    <= alu_o;
            res_zero    <= (alu_o == '0);
            res_illegal <= op_undef;
            res_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_cnt    <= op_cnt + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a two-stage registered ALU model.
module tb_alu_driver;
  localparam int W = 8;

  logic         ck = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_op = '0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic [W-1:0] alu_a, alu_b;
  logic [3:0]   alu_ctr;
  logic [W-1:0] alu_o = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic [3:0]   res_op;
  logic         res_zero, res_illegal, busy;
  logic [15:0]  op_cnt;

  // Small-counter instance used only to reach the wrap point quickly
  logic         w_valid = 1'b0;
  logic         w_ready = 1'b0;
  logic         w_cmd_ready, w_res_valid, w_res_zero, w_res_illegal, w_busy;
  logic [3:0]   w_op = '0;
  logic [W-1:0] w_a = '0, w_b = '0, w_alu_o = '0;
  logic [W-1:0] w_alu_a, w_alu_b, w_res_data;
  logic [3:0]   w_alu_ctr, w_res_op;
  logic [2:0]   w_op_cnt;

  int           checks = 0;
  int           passed = 0;
  logic [15:0]  exp_cnt = '0;
  logic [W-1:0] alu_s1;

  always #5 ck = ~ck;

  alu_driver #(.W(W), .ALU_LAT(2), .CNT_W(16)) dut (
    .ck(ck), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_a(alu_a),
    .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_o(alu_o), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_op(res_op),
    .res_zero(res_zero), .res_illegal(res_illegal), .busy(busy),
    .op_cnt(op_cnt)
  );

  alu_driver #(.W(W), .ALU_LAT(2), .CNT_W(3)) wrap_dut (
    .ck(ck), .rst_n(rst_n), .cmd_valid(w_valid), .cmd_ready(w_cmd_ready),
    .cmd_op(w_op), .cmd_a(w_a), .cmd_b(w_b), .alu_a(w_alu_a),
    .alu_b(w_alu_b), .alu_ctr(w_alu_ctr), .alu_o(w_alu_o),
    .res_valid(w_res_valid), .res_ready(w_ready), .res_data(w_res_data),
    .res_op(w_res_op), .res_zero(w_res_zero), .res_illegal(w_res_illegal),
    .busy(w_busy), .op_cnt(w_op_cnt)
  );

  function automatic logic [W-1:0] alu_f(input logic [3:0] op,
                                         input logic [W-1:0] a, b);
    case (op)
      4'b0000: alu_f = a + b;
      4'b0001: alu_f = a - b;
      4'b1110: alu_f = {a[0], a[W-1:1]};
      4'b1111: alu_f = {a[W-2:0], a[W-1]};
      default: alu_f = '0;
    endcase
  endfunction

  // ALU: captures inputs on one edge, updates O on the next; no reset.
  always @(posedge ck) begin
    alu_s1 <= alu_f(alu_ctr, alu_a, alu_b);
    alu_o  <= alu_s1;
  end

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, b,
                        input logic [W-1:0] exp_d, input logic exp_z, exp_i,
                        input string name);
    int n;
    @(negedge ck);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; res_ready = 1'b1;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge ck);
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL %s accept: cmd_ready=%b want 1", name, cmd_ready);
    else passed++;
    @(posedge ck);
    @(negedge ck);
    cmd_valid = 1'b0;
    checks++;
    if (alu_a !== a) $display("FAIL %s alu_a: got %h want %h", name, alu_a, a);
    else passed++;
    checks++;
    if (alu_b !== b) $display("FAIL %s alu_b: got %h want %h", name, alu_b, b);
    else passed++;
    checks++;
    if (alu_ctr !== op) $display("FAIL %s alu_ctr: got %h want %h", name, alu_ctr, op);
    else passed++;
    checks++;
    if (busy !== 1'b1) $display("FAIL %s busy: got %b want 1", name, busy);
    else passed++;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge ck);
      n++;
    end
    checks++;
    if (n != 3) $display("FAIL %s latency: got %0d edges want 3", name, n);
    else passed++;
    checks++;
    if (res_data !== exp_d) $display("FAIL %s res_data: got %h want %h", name, res_data, exp_d);
    else passed++;
    checks++;
    if (res_zero !== exp_z) $display("FAIL %s res_zero: got %b want %b", name, res_zero, exp_z);
    else passed++;
    checks++;
    if (res_illegal !== exp_i) $display("FAIL %s res_illegal: got %b want %b", name, res_illegal, exp_i);
    else passed++;
    checks++;
    if (res_op !== op) $display("FAIL %s res_op: got %h want %h", name, res_op, op);
    else passed++;
    @(negedge ck);
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (res_valid !== 1'b0) $display("FAIL %s handshake: res_valid=%b want 0", name, res_valid);
    else passed++;
    checks++;
    if (op_cnt !== exp_cnt) $display("FAIL %s op_cnt: got %0d want %0d", name, op_cnt, exp_cnt);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge ck);
    checks++;
    if (cmd_ready !== 1'b0) $display("FAIL reset cmd_ready: got %b want 0", cmd_ready);
    else passed++;
    checks++;
    if ({res_valid, busy, res_zero, res_illegal} !== 4'b0000)
      $display("FAIL reset flags: got %b want 0000", {res_valid, busy, res_zero, res_illegal});
    else passed++;
    checks++;
    if ({alu_a, alu_b, alu_ctr, res_data, res_op} !== 36'h0)
      $display("FAIL reset regs: got %h want 0", {alu_a, alu_b, alu_ctr, res_data, res_op});
    else passed++;
    checks++;
    if (op_cnt !== 16'h0) $display("FAIL reset op_cnt: got %0d want 0", op_cnt);
    else passed++;
    rst_n = 1'b1;
    @(negedge ck);
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset release cmd_ready: got %b want 1", cmd_ready);
    else passed++;
  endtask

  task automatic test_add();
    run_op(4'b0000, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, "add");
  endtask

  task automatic test_sub();
    run_op(4'b0001, 8'h03, 8'h03, 8'h00, 1'b1, 1'b0, "sub_zero");
    run_op(4'b0001, 8'h02, 8'h05, 8'hFD, 1'b0, 1'b0, "sub_neg");
  endtask

  task automatic test_rot_illegal();
    run_op(4'b1110, 8'h01, 8'h00, 8'h80, 1'b0, 1'b0, "ror");
    run_op(4'b1111, 8'h80, 8'h00, 8'h01, 1'b0, 1'b0, "rol");
    run_op(4'b0101, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1, "illegal_0101");
    run_op(4'b0010, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1, "illegal_0010");
    run_op(4'b0111, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1, "illegal_0111");
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    @(negedge ck);
    cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_a = 8'h10; cmd_b = 8'h20;
    res_ready = 1'b0;
    @(posedge ck);
    @(negedge ck);
    cmd_op = 4'b0001; cmd_a = 8'h09; cmd_b = 8'h04;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge ck);
      n++;
    end
    checks++;
    if (res_valid !== 1'b1) $display("FAIL bp result: res_valid=%b want 1", res_valid);
    else passed++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid !== 1'b1 || res_data !== 8'h30 || res_op !== 4'b0000 ||
          cmd_ready !== 1'b0 || busy !== 1'b1 || alu_a !== 8'h10)
        bad++;
      @(negedge ck);
    end
    checks++;
    if (bad != 0) $display("FAIL bp hold: %0d unstable cycles want 0 (data %h cmd_ready %b)", bad, res_data, cmd_ready);
    else passed++;
    checks++;
    if (op_cnt !== exp_cnt) $display("FAIL bp op_cnt held: got %0d want %0d", op_cnt, exp_cnt);
    else passed++;
    res_ready = 1'b1;
    @(negedge ck);
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if ({res_valid, busy, cmd_ready} !== 3'b001)
      $display("FAIL bp release: valid/busy/ready got %b want 001", {res_valid, busy, cmd_ready});
    else passed++;
    checks++;
    if (op_cnt !== exp_cnt) $display("FAIL bp op_cnt: got %0d want %0d", op_cnt, exp_cnt);
    else passed++;
    @(negedge ck);
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || alu_a !== 8'h09 || alu_ctr !== 4'b0001)
      $display("FAIL bp pending accept: busy %b alu_a %h ctr %h want 1 09 1", busy, alu_a, alu_ctr);
    else passed++;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge ck);
      n++;
    end
    checks++;
    if (res_data !== 8'h05) $display("FAIL bp pending result: got %h want 05", res_data);
    else passed++;
    @(negedge ck);
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_reset_midop();
    int seen;
    @(negedge ck);
    cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_a = 8'h44; cmd_b = 8'h11;
    res_ready = 1'b1;
    @(posedge ck);
    @(negedge ck);
    cmd_valid = 1'b0;
    @(negedge ck);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({res_valid, busy, cmd_ready} !== 3'b000)
      $display("FAIL midop reset flags: got %b want 000", {res_valid, busy, cmd_ready});
    else passed++;
    checks++;
    if (op_cnt !== 16'h0) $display("FAIL midop reset op_cnt: got %0d want 0", op_cnt);
    else passed++;
    exp_cnt = '0;
    @(negedge ck);
    rst_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL midop release cmd_ready: got %b want 1", cmd_ready);
    else passed++;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ck);
      if (res_valid) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL midop discard: res_valid seen %0d times want 0", seen);
    else passed++;
    run_op(4'b0000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "post_reset_add");
  endtask

  task automatic test_wrap();
    int n;
    w_ready = 1'b1;
    w_valid = 1'b1;
    n = 0;
    while (w_op_cnt != 3'd7 && n < 200) begin
      @(negedge ck);
      n++;
    end
    checks++;
    if (w_op_cnt !== 3'd7) $display("FAIL wrap reach max: got %0d want 7", w_op_cnt);
    else passed++;
    n = 0;
    while (!w_res_valid && n < 20) begin
      @(negedge ck);
      n++;
    end
    @(negedge ck);
    checks++;
    if (w_op_cnt !== 3'd0) $display("FAIL wrap: got %0d want 0", w_op_cnt);
    else passed++;
    w_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_rot_illegal();
    test_backpressure();
    test_reset_midop();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
